// File: rtl/fifo_pkg.sv
// fifo_pkg: state encodings, widths and destination-field helpers shared by
// the demux controller and its FSM.
package fifo_pkg;
  localparam int DATA_W  = 6;
  localparam int TH_W    = 5;
  localparam int NUM_DST = 4;
  localparam int DST_MSB = 5;
  localparam int DST_LSB = 4;
  localparam int DST_W   = DST_MSB - DST_LSB + 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Destination index carried in the top bits of each word.
  function automatic logic [DST_W-1:0] dst_of(input logic [DATA_W-1:0] w);
    return w[DST_MSB:DST_LSB];
  endfunction
endpackage

// File: rtl/fifo_demux_fsm.sv
// fifo_demux_fsm: sequencing state machine for the demux controller.
// Error detection has priority over every other transition and is sticky.
module fifo_demux_fsm
  import fifo_pkg::*;
(
  input  logic   clk,
  input  logic   RESET_L,
  input  logic   init,
  input  logic   up_empty,
  input  logic   in_flight,
  input  logic   err_hit,
  output state_t state,
  output logic   idle,
  output logic   err
);

  // state register plus registered idle/err flags, decided alongside state
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= ST_RESET;
      idle  <= 1'b0;
      err   <= 1'b0;
    end else begin
      idle <= 1'b0;
      if (state == ST_ERROR) begin
        err <= 1'b1;
      end else if (err_hit) begin
        state <= ST_ERROR;
        err   <= 1'b1;
      end else begin
        case (state)
          ST_RESET: state <= ST_INIT;
          ST_INIT: begin
            if (!init) begin
              state <= ST_IDLE;
              idle  <= 1'b1;
            end
          end
          ST_IDLE: begin
            if (init)           state <= ST_INIT;
            else if (!up_empty) state <= ST_ACTIVE;
            else                idle  <= 1'b1;
          end
          ST_ACTIVE: begin
            // words already popped finish on their own; only popping stops
            if (init) begin
              state <= ST_INIT;
            end else if (up_empty && !in_flight) begin
              state <= ST_IDLE;
              idle  <= 1'b1;
            end
          end
          default: begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/fifo_demux_ctrl.sv
// fifo_demux_ctrl: drains the upstream FIFO and routes each word to one of
// NUM_DST downstream FIFOs by its destination field. Pop-to-write latency is
// two cycles: one for the upstream read, one for the routing register.
module fifo_demux_ctrl #(
  parameter int DATA_W  = fifo_pkg::DATA_W,
  parameter int TH_W    = fifo_pkg::TH_W,
  parameter int NUM_DST = fifo_pkg::NUM_DST
) (
  input  logic               clk,
  input  logic               RESET_L,
  input  logic               init,
  input  logic [TH_W-1:0]    al_empty_th_in,
  input  logic [TH_W-1:0]    al_full_th_in,
  output logic [TH_W-1:0]    al_empty_th,
  output logic [TH_W-1:0]    al_full_th,
  input  logic               up_empty,
  input  logic [DATA_W-1:0]  up_data,
  output logic               up_rd,
  input  logic [NUM_DST-1:0] dn_al_full,
  input  logic [NUM_DST-1:0] dn_full,
  output logic [NUM_DST-1:0] dn_wr,
  output logic [DATA_W-1:0]  dn_data,
  output logic [2:0]         state,
  output logic               idle,
  output logic               err
);
  import fifo_pkg::*;

  localparam int STAGES = 1;

  state_t          st;
  // [0]: popped word is on up_data, [1]: routed word is on dn_data/dn_wr
  logic [STAGES:0] vld_pipe;
  logic            err_hit;
  logic            kill;

  // Destination is unknown until the word arrives, so any almost-full
  // downstream stalls every pop.
  assign up_rd   = (st == ST_ACTIVE) && !up_empty && !(|dn_al_full) && !init;
  assign err_hit = |(dn_wr & dn_full);
  assign kill    = err_hit || (st == ST_ERROR);
  assign state   = st;

  fifo_demux_fsm u_fsm (
    .clk       (clk),
    .RESET_L   (RESET_L),
    .init      (init),
    .up_empty  (up_empty),
    .in_flight (|vld_pipe),
    .err_hit   (err_hit),
    .state     (st),
    .idle      (idle),
    .err       (err)
  );

  // valid shift register; an error drops the word that would be written next
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[STAGES-1] && !kill, up_rd};
  end

  // routing register: dn_data holds its last value between writes
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      dn_data <= '0;
    end else if (vld_pipe[0] && !kill) begin
      dn_data <= up_data;
    end
  end

  // per-destination one-hot write strobes, registered
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      dn_wr <= '0;
    end else begin
      for (int i = 0; i < NUM_DST; i++)
        dn_wr[i] <= vld_pipe[0] && !kill && (dst_of(up_data) == DST_W'(i));
    end
  end

  // thresholds track their inputs for as long as the FSM sits in INIT
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      al_empty_th <= '0;
      al_full_th  <= '0;
    end else if (st == ST_INIT) begin
      al_empty_th <= al_empty_th_in;
      al_full_th  <= al_full_th_in;
    end
  end

endmodule

// File: tb/tb_fifo_demux_ctrl.sv
// tb_fifo_demux_ctrl: upstream FIFO model plus an in-order scoreboard that
// expects every popped word two cycles later on its one-hot strobe.
module tb_fifo_demux_ctrl;
  logic       clk = 1'b0;
  logic       RESET_L, init, up_empty, up_rd, idle, err;
  logic [4:0] al_empty_th_in, al_full_th_in, al_empty_th, al_full_th;
  logic [5:0] up_data, dn_data;
  logic [3:0] dn_al_full, dn_full, dn_wr;
  logic [2:0] state;

  int checks = 0, failures = 0;
  int cyc = 0, pop_cnt = 0, wr_cnt = 0, wr8_cnt = 0;
  bit sb_on = 1'b0;
  logic [5:0] uq[$], exp_q[$], pend_w[$];
  int pend_due[$];
  logic [5:0] mon_w;

  always #5 clk = ~clk;

  fifo_demux_ctrl dut (
    .clk(clk), .RESET_L(RESET_L), .init(init),
    .al_empty_th_in(al_empty_th_in), .al_full_th_in(al_full_th_in),
    .al_empty_th(al_empty_th), .al_full_th(al_full_th),
    .up_empty(up_empty), .up_data(up_data), .up_rd(up_rd),
    .dn_al_full(dn_al_full), .dn_full(dn_full), .dn_wr(dn_wr),
    .dn_data(dn_data), .state(state), .idle(idle), .err(err)
  );

  // upstream FIFO: data valid the cycle after the pop
  always @(posedge clk) begin
    if (up_rd && uq.size() > 0) up_data <= uq.pop_front();
    up_empty <= (uq.size() == 0);
  end

  // scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (sb_on) begin
      checks++;
      if (up_rd && (up_empty || (|dn_al_full) || init)) begin
        failures++;
        $display("FAIL pop_rule: up_rd=1 with up_empty=%b dn_al_full=%b init=%b, required up_rd=0",
                 up_empty, dn_al_full, init);
      end
      checks++;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mon_w = pend_w.pop_front();
        pend_due.delete(0);
        if (dn_wr !== (4'b0001 << mon_w[5:4]) || dn_data !== mon_w) begin
          failures++;
          $display("FAIL route: dn_wr=%b dn_data=%h, required dn_wr=%b dn_data=%h",
                   dn_wr, dn_data, 4'b0001 << mon_w[5:4], mon_w);
        end
      end else if (dn_wr !== 4'b0000) begin
        failures++;
        $display("FAIL spurious_wr: dn_wr=%b at cycle %0d, required 0000", dn_wr, cyc);
      end
      if (up_rd) begin
        pop_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_extra: pop with no word pending, got up_rd=1 required 0");
        end else begin
          pend_w.push_back(exp_q.pop_front());
          pend_due.push_back(cyc + 2);
        end
      end
    end
    if (dn_wr != 4'b0000) wr_cnt++;
    if (dn_wr == 4'b1000) wr8_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [5:0] w);
    uq.push_back(w);
    exp_q.push_back(w);
    up_empty = 1'b0;
  endtask

  task automatic flush_model();
    uq.delete(); exp_q.delete(); pend_w.delete(); pend_due.delete();
    up_empty = 1'b1;
  endtask

  task automatic bring_up();
    sb_on = 1'b0; RESET_L = 1'b0; init = 1'b1; dn_al_full = '0; dn_full = '0;
    flush_model();
    tick(); tick();
    RESET_L = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick(); tick();
    sb_on = 1'b1;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int n = 0;
    while (!(state == 3'd2 && up_empty && pend_due.size() == 0) && n < bound) begin
      tick(); n++;
    end
    ok = (state == 3'd2 && up_empty && pend_due.size() == 0);
  endtask

  task automatic test_reset();
    RESET_L = 1'b0; init = 1'b1; al_empty_th_in = 5'd2; al_full_th_in = 5'd6;
    dn_al_full = '0; dn_full = '0; up_empty = 1'b1; up_data = '0;
    tick();
    checks++;
    if ({state, up_rd, dn_wr, dn_data, al_empty_th, al_full_th, idle, err} !== 26'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required all zero",
               {state, up_rd, dn_wr, dn_data, al_empty_th, al_full_th, idle, err});
    end
    tick();
    RESET_L = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1 || idle !== 1'b0) begin
      failures++;
      $display("FAIL reset_to_init: state=%0d idle=%b, required state=1 idle=0", state, idle);
    end
    tick();
    checks++;
    if (al_empty_th !== 5'd2 || al_full_th !== 5'd6) begin
      failures++;
      $display("FAIL th_load: got %0d/%0d, required 2/6", al_empty_th, al_full_th);
    end
    init = 1'b0;
    tick();
    checks++;
    if (state !== 3'd2 || idle !== 1'b1) begin
      failures++;
      $display("FAIL init_to_idle: state=%0d idle=%b, required state=2 idle=1", state, idle);
    end
    sb_on = 1'b1;
  endtask

  task automatic test_routing();
    logic [5:0] words [4];
    logic [3:0] exp_wr [4];
    bit ok;
    words  = '{6'b010010, 6'b100100, 6'b110110, 6'b000011};
    exp_wr = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) push(words[i]);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        checks++;
        if (up_rd !== 1'b1) begin
          failures++;
          $display("FAIL route_pop%0d: up_rd=%b, required 1", k, up_rd);
        end
      end
      if (k >= 2) begin
        checks++;
        if (dn_wr !== exp_wr[k-2] || dn_data !== words[k-2]) begin
          failures++;
          $display("FAIL route_wr%0d: dn_wr=%b dn_data=%h, required %b/%h",
                   k - 2, dn_wr, dn_data, exp_wr[k-2], words[k-2]);
        end
      end
      tick();
    end
    checks++;
    if (up_rd !== 1'b0 || dn_wr !== 4'b0000) begin
      failures++;
      $display("FAIL route_tail: up_rd=%b dn_wr=%b, required 0/0000", up_rd, dn_wr);
    end
    wait_idle(10, ok);
    checks++;
    if (!ok || idle !== 1'b1) begin
      failures++;
      $display("FAIL route_idle: state=%0d idle=%b, required state=2 idle=1", state, idle);
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    for (int i = 0; i < 8; i++) push(6'($urandom_range(0, 63)));
    tick(); tick(); tick();
    dn_al_full = 4'b0100;
    base = wr_cnt;
    #1;
    checks++;
    if (up_rd !== 1'b0) begin
      failures++;
      $display("FAIL bp_stop: up_rd=%b, required 0", up_rd);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (up_rd !== 1'b0 || state !== 3'd3) begin
        failures++;
        $display("FAIL bp_hold%0d: up_rd=%b state=%0d, required 0/3", k, up_rd, state);
      end
    end
    checks++;
    if (wr_cnt - base > 2) begin
      failures++;
      $display("FAIL bp_inflight: %0d writes after stall, required at most 2", wr_cnt - base);
    end
    dn_al_full = 4'b0000;
    #1;
    checks++;
    if (up_rd !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume: up_rd=%b, required 1", up_rd);
    end
    wait_idle(30, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: state=%0d left=%0d, required state=2 left=0", state, exp_q.size());
    end
  endtask

  task automatic test_empty_boundary();
    int base_pop, base_w8;
    bit ok;
    push(6'b000001);
    tick(); tick();
    checks++;
    if (up_rd !== 1'b0 || state !== 3'd3) begin
      failures++;
      $display("FAIL eb_empty: up_rd=%b state=%0d, required 0/3", up_rd, state);
    end
    base_pop = pop_cnt;
    base_w8  = wr8_cnt;
    push(6'b110000);
    #1;
    checks++;
    if (up_rd !== 1'b1) begin
      failures++;
      $display("FAIL eb_pop: up_rd=%b, required 1", up_rd);
    end
    wait_idle(10, ok);
    checks++;
    if (!ok || pop_cnt - base_pop != 1 || wr8_cnt - base_w8 != 1) begin
      failures++;
      $display("FAIL eb_count: pops=%0d wr1000=%0d idle_ok=%b, required 1/1/1",
               pop_cnt - base_pop, wr8_cnt - base_w8, ok);
    end
  endtask

  task automatic test_init_mid();
    int base;
    bit ok;
    logic [4:0] th_e, th_f;
    th_e = 5'($urandom_range(0, 31));
    th_f = 5'($urandom_range(0, 31));
    for (int i = 0; i < 6; i++) push(6'($urandom_range(0, 63)));
    tick(); tick(); tick();
    init = 1'b1; al_empty_th_in = th_e; al_full_th_in = th_f;
    base = wr_cnt;
    #1;
    checks++;
    if (up_rd !== 1'b0) begin
      failures++;
      $display("FAIL init_stop: up_rd=%b, required 0", up_rd);
    end
    tick();
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL init_state: state=%0d, required 1", state);
    end
    tick(); tick();
    checks++;
    if (wr_cnt - base != 2) begin
      failures++;
      $display("FAIL init_inflight: %0d writes, required 2", wr_cnt - base);
    end
    checks++;
    if (al_empty_th !== th_e || al_full_th !== th_f) begin
      failures++;
      $display("FAIL init_th: got %0d/%0d, required %0d/%0d", al_empty_th, al_full_th, th_e, th_f);
    end
    init = 1'b0;
    wait_idle(30, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL init_resume: state=%0d left=%0d, required state=2 left=0", state, exp_q.size());
    end
  endtask

  task automatic test_random();
    int pushed, base_pop;
    bit ok;
    pushed = 0;
    base_pop = pop_cnt;
    for (int c = 0; c < 150; c++) begin
      tick();
      if ($urandom_range(0, 1) == 1) begin
        push(6'($urandom_range(0, 63)));
        pushed++;
      end
      dn_al_full = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
    end
    tick();
    dn_al_full = 4'b0000;
    wait_idle(300, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || pop_cnt - base_pop != pushed) begin
      failures++;
      $display("FAIL random_drain: pops=%0d pushed=%0d idle_ok=%b, required equal and idle",
               pop_cnt - base_pop, pushed, ok);
    end
  endtask

  task automatic test_error();
    logic [5:0] w;
    int n;
    w = 6'b010000 | 6'($urandom_range(0, 15));
    dn_full = 4'b0010;
    push(w);
    n = 0;
    while (dn_wr === 4'b0000 && n < 10) begin tick(); n++; end
    checks++;
    if (dn_wr !== 4'b0010 || dn_data !== w) begin
      failures++;
      $display("FAIL err_wr: dn_wr=%b dn_data=%h, required 0010/%h", dn_wr, dn_data, w);
    end
    tick();
    checks++;
    if (state !== 3'd4 || err !== 1'b1 || dn_wr !== 4'b0000 || up_rd !== 1'b0) begin
      failures++;
      $display("FAIL err_enter: state=%0d err=%b dn_wr=%b up_rd=%b, required 4/1/0000/0",
               state, err, dn_wr, up_rd);
    end
    for (int i = 0; i < 3; i++) push(6'($urandom_range(0, 63)));
    dn_full = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (state !== 3'd4 || err !== 1'b1 || dn_wr !== 4'b0000 || up_rd !== 1'b0) begin
        failures++;
        $display("FAIL err_hold%0d: state=%0d err=%b dn_wr=%b up_rd=%b, required 4/1/0000/0",
                 k, state, err, dn_wr, up_rd);
      end
    end
    bring_up();
    checks++;
    if (state !== 3'd2 || err !== 1'b0) begin
      failures++;
      $display("FAIL err_reset: state=%0d err=%b, required 2/0", state, err);
    end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 6; i++) push(6'($urandom_range(0, 63)));
    n = 0;
    while (dn_wr === 4'b0000 && n < 10) begin tick(); n++; end
    checks++;
    if (dn_wr === 4'b0000) begin
      failures++;
      $display("FAIL ar_start: dn_wr=0000 after %0d cycles, required a write", n);
    end
    #2;
    sb_on = 1'b0;
    RESET_L = 1'b0;
    #1;
    checks++;
    if (dn_wr !== 4'b0000 || up_rd !== 1'b0 || state !== 3'd0 || dn_data !== 6'd0 ||
        al_empty_th !== 5'd0 || al_full_th !== 5'd0) begin
      failures++;
      $display("FAIL ar_clear: dn_wr=%b up_rd=%b state=%0d dn_data=%h th=%0d/%0d, required all 0",
               dn_wr, up_rd, state, dn_data, al_empty_th, al_full_th);
    end
    bring_up();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_empty_boundary();
    test_init_mid();
    test_random();
    test_error();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
